vdf_square_seq: RTL and testbench

- Iterated modular-squaring sequencer for the VDF datapath. Computes x^(2^T) mod MODULUS.
- Accepts a start request (x, T). Feeds the current value as both operands to the pipelined modular multiplier, one square in flight at a time, and captures each result back as the next operand.
- Multiplier results are only partially reduced, so a final conditional-subtract stage brings the answer into [0, MODULUS) before it is presented downstream.

---
 rtl/vdf_square_seq.sv | 126 ++++++++++++
 tb/tb_vdf_square_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdf_square_seq.sv
// Iterated modular-squaring sequencer: computes x^(2^T) mod MODULUS using an external
// pipelined multiplier, then fully reduces the partially-reduced result before presenting it.
module vdf_square_seq #(
  parameter int              BITS    = 1024,
  parameter logic [BITS-1:0] MODULUS = {BITS{1'b1}},
  parameter int              T_W     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_val,
  output logic            o_rdy,
  input  logic [BITS-1:0] i_x,
  input  logic [T_W-1:0]  i_t,
  output logic            o_val,
  input  logic            i_rdy,
  output logic [BITS-1:0] o_dat,
  output logic            o_mul_val,
  input  logic            i_mul_rdy,
  output logic [BITS-1:0] o_mul_a,
  output logic [BITS-1:0] o_mul_b,
  input  logic            i_mul_val,
  output logic            o_mul_rdy,
  input  logic [BITS-1:0] i_mul_dat,
  output logic [T_W-1:0]  o_iter,
  output logic            o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] cur_q, cur_d;
  logic [BITS-1:0] dat_q, dat_d;
  logic [T_W-1:0]  cnt_q, cnt_d;
  logic [T_W-1:0]  iter_q, iter_d;
  logic            err_q, err_d;

  // One extra bit so the borrow says whether cur >= MODULUS, with no wraparound.
  logic [BITS:0]   diff;
  logic            cur_ge_mod;

  assign diff       = {1'b0, cur_q} - {1'b0, MODULUS};
  assign cur_ge_mod = ~diff[BITS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a hold-value default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_val) begin
          cur_d   = i_x;
          cnt_d   = i_t;
          iter_d  = '0;
          state_d = (i_t == '0) ? S_REDUCE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_mul_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_mul_val) begin
          cur_d   = i_mul_dat;
          cnt_d   = cnt_q - T_W'(1);
          iter_d  = iter_q + T_W'(1);
          state_d = (cnt_q == T_W'(1)) ? S_REDUCE : S_ISSUE;
        end
      end
      S_REDUCE: begin
        if (cur_ge_mod) begin
          cur_d = diff[BITS-1:0];
        end else begin
          dat_d   = cur_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A result arriving when none is outstanding is dropped and flagged until reset.
    if (i_mul_val && (state_q != S_WAIT)) err_d = 1'b1;
  end

  always_comb begin
    o_rdy     = (state_q == S_IDLE);
    o_mul_val = (state_q == S_ISSUE);
    o_mul_rdy = (state_q == S_WAIT);
    o_val     = (state_q == S_DONE);
    o_mul_a   = cur_q;
    o_mul_b   = cur_q;
    o_dat     = dat_q;
    o_iter    = iter_q;
    o_err     = err_q;
  end

endmodule

// File: tb/tb_vdf_square_seq.sv
// Bench for vdf_square_seq: latency-7 partially-reducing multiplier model, arithmetic
// reference for x^(2^T) mod M, a per-cycle output monitor and directed jobs.
module tb_vdf_square_seq;

  localparam int          BITS = 16;
  localparam int          T_W  = 32;
  localparam logic [15:0] MOD  = 16'hFFF1;
  localparam longint      M    = 65521;
  localparam int          LAT  = 7;
  localparam int          BUDGET = 300;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_val = 1'b0;
  logic            o_rdy;
  logic [BITS-1:0] i_x = '0;
  logic [T_W-1:0]  i_t = '0;
  logic            o_val;
  logic            i_rdy = 1'b0;
  logic [BITS-1:0] o_dat;
  logic            o_mul_val;
  logic            mul_rdy = 1'b1;
  logic [BITS-1:0] o_mul_a, o_mul_b;
  logic            i_mul_val;
  logic            o_mul_rdy;
  logic [BITS-1:0] i_mul_dat;
  logic [T_W-1:0]  o_iter;
  logic            o_err;

  // Multiplier model state
  logic            mdl_val = 1'b0;
  logic [BITS-1:0] mdl_dat = '0;
  logic [BITS-1:0] mdl_res = '0;
  logic            mdl_pend = 1'b0;
  int              mdl_cnt = 0;
  int              hs_cnt = 0;
  logic            stray_val = 1'b0;

  // Expectations written by the stimulus, read by the monitor
  longint exp_x = 0;
  int     exp_t = 0;
  longint exp_dat = 0;
  logic   exp_err = 1'b0;
  int     hs_base = 0;

  int n_checks = 0;
  int n_errors = 0;

  assign i_mul_val = mdl_val | stray_val;
  assign i_mul_dat = mdl_dat;

  vdf_square_seq #(.BITS(BITS), .MODULUS(MOD), .T_W(T_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_val(i_val), .o_rdy(o_rdy), .i_x(i_x), .i_t(i_t),
    .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat),
    .o_mul_val(o_mul_val), .i_mul_rdy(mul_rdy), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_val(i_mul_val), .o_mul_rdy(o_mul_rdy), .i_mul_dat(i_mul_dat),
    .o_iter(o_iter), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mul_f(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = (longint'(a) * longint'(b)) % M;
    if (p + M < 65536) return 16'(p + M);
    return 16'(p);
  endfunction

  function automatic longint ref_pow(input longint x, input int t);
    longint v;
    v = x % M;
    for (int i = 0; i < t; i++) v = (v * v) % M;
    return v;
  endfunction

  // Number of final subtractions the sequencer must perform.
  function automatic int ref_r(input longint x, input int t);
    if (t == 0) return (x >= M) ? 1 : 0;
    return (ref_pow(x, t) + M < 65536) ? 1 : 0;
  endfunction

  // Operands accepted on a handshake come back LAT cycles later; reset discards them.
  always @(posedge clk) begin
    if (rst) begin
      mdl_val  <= 1'b0;
      mdl_pend <= 1'b0;
      mdl_cnt  <= 0;
    end else begin
      if (mdl_val && o_mul_rdy) mdl_val <= 1'b0;
      if (o_mul_val && mul_rdy) begin
        mdl_pend <= 1'b1;
        mdl_cnt  <= LAT;
        mdl_res  <= mul_f(o_mul_a, o_mul_b);
        hs_cnt   <= hs_cnt + 1;
      end else if (mdl_pend) begin
        if (mdl_cnt == 1) begin
          mdl_val  <= 1'b1;
          mdl_dat  <= mdl_res;
          mdl_pend <= 1'b0;
        end
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        check("mon_err", o_err, exp_err);
        if (o_val) begin
          check("mon_dat", o_dat, exp_dat);
          check("mon_iter", o_iter, exp_t);
          check("mon_range", (longint'(o_dat) < M), 1);
          check("mon_rdy_low", o_rdy, 0);
        end
        if (o_mul_val) begin
          check("mon_opa", longint'(o_mul_a) % M, ref_pow(exp_x, hs_cnt - hs_base));
          check("mon_opb", o_mul_b, o_mul_a);
        end
      end
    end
  endtask

  task automatic set_job(input longint x, input int t);
    exp_x   = x;
    exp_t   = t;
    exp_dat = ref_pow(x, t);
    hs_base = hs_cnt;
  endtask

  task automatic wait_val(inout int n);
    while (!o_val && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!o_val) check("timeout_o_val", 0, 1);
  endtask

  task automatic accept_result();
    i_rdy = 1'b1;
    @(negedge clk);
    i_rdy = 1'b0;
    check("val_drop", o_val, 0);
    check("rdy_back", o_rdy, 1);
  endtask

  task automatic run_job(input longint x, input int t, input longint lit);
    int n;
    set_job(x, t);
    @(negedge clk);
    i_val = 1'b1;
    i_x   = 16'(x);
    i_t   = T_W'(t);
    @(negedge clk);
    i_val = 1'b0;
    n = 1;
    wait_val(n);
    check("latency", n, t * (LAT + 2) + ref_r(x, t) + 2);
    check("dat_model", o_dat, exp_dat);
    check("dat_literal", o_dat, lit);
    check("iter", o_iter, t);
    check("mul_handshakes", hs_cnt - hs_base, t);
    accept_result();
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_rdy", o_rdy, 1);
    check("rst_val", o_val, 0);
    check("rst_mul_val", o_mul_val, 0);
    check("rst_mul_rdy", o_mul_rdy, 0);
    check("rst_dat", o_dat, 0);
    check("rst_iter", o_iter, 0);
    check("rst_err", o_err, 0);

    run_job(3, 1, 9);
    run_job(3, 4, 64945);
    run_job(16'hFFFF, 0, 14);

    // Multiplier backpressure in ISSUE, then downstream backpressure in DONE.
    set_job(5, 2);
    mul_rdy = 1'b0;
    @(negedge clk);
    i_val = 1'b1;
    i_x   = 16'd5;
    i_t   = T_W'(2);
    @(negedge clk);
    i_val = 1'b0;
    n = 1;
    repeat (5) begin
      check("stall_mul_val", o_mul_val, 1);
      check("stall_opa", o_mul_a, 5);
      check("stall_opb", o_mul_b, 5);
      @(negedge clk);
      n++;
    end
    mul_rdy = 1'b1;
    wait_val(n);
    check("stall_latency", n, 2 * (LAT + 2) + 0 + 2 + 5);
    check("stall_dat_literal", o_dat, 625);
    for (int k = 0; k < 10; k++) begin
      check("hold_val", o_val, 1);
      check("hold_dat", o_dat, 625);
      check("hold_rdy", o_rdy, 0);
      i_val = (k == 3);
      i_x   = 16'd7;
      i_t   = '0;
      @(negedge clk);
    end
    i_val = 1'b0;
    accept_result();
    repeat (3) begin
      @(negedge clk);
      check("ignored_start_val", o_val, 0);
      check("ignored_start_mul", o_mul_val, 0);
      check("ignored_start_rdy", o_rdy, 1);
    end

    // Reset in WAIT after two squarings completed.
    set_job(3, 4);
    @(negedge clk);
    i_val = 1'b1;
    i_x   = 16'd3;
    i_t   = T_W'(4);
    @(negedge clk);
    i_val = 1'b0;
    n = 0;
    while (!(hs_cnt - hs_base == 3 && o_mul_rdy) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("mid_iter", o_iter, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rdy", o_rdy, 1);
    check("abort_val", o_val, 0);
    check("abort_mul_val", o_mul_val, 0);
    check("abort_iter", o_iter, 0);
    run_job(3, 1, 9);

    // Stray multiplier result while idle.
    @(negedge clk);
    stray_val = 1'b1;
    exp_err   = 1'b1;
    @(negedge clk);
    stray_val = 1'b0;
    check("stray_err", o_err, 1);
    run_job(2, 2, 16);
    check("err_sticky", o_err, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
